jtopl_cpu_fifo: RTL and testbench
=================================

// Module: jtopl_cpu_fifo
// PURPOSE
// - Parametrised CPU-side write front end for the OPL core. It sits between the host bus and jtopl_mmr.
// - Latches address writes and queues data writes as {bank,reg,data} entries in a FIFO.
// - Replays queued entries to the register file paced on cenop, honouring the chip write-recovery time.
// - Handles 1-bank (OPL2) or 2-bank (OPL3-style) addressing, and builds the status byte read by the host.
// PARAMETERS
// - FIFO_DEPTH  4   entries; power of two, 2..16
// - BANKS       1   1 = single register bank, addr is 1 bit; 2 = bank select taken from addr[1]
// - DATA_WAIT   84  cenop cycles between two consecutive mmr writes (recovery time)
// PORTS
// - clk        in   1                      system clock
// - rst_n      in   1                      asynchronous, active-low reset
// - cenop      in   1                      operator clock enable; paces issue and wait counter
// - din        in   8                      host data bus
// - addr       in   BANKS                  addr[0]: 0 = address port, 1 = data port; addr[1] = bank when BANKS=2
// - cs_n       in   1                      chip select, active low
// - wr_n       in   1                      write strobe, active low
// - flag_A     in   1                      timer A flag, status bit 6
// - flag_B     in   1                      timer B flag, status bit 5
// - irq_n      in   1                      timer IRQ, status bit 7 = ~irq_n
// - dout       out  8                      status byte
// - busy       out  1                      FIFO non-empty or recovery wait in progress
// - mmr_write  out  1                      single-clk write pulse to the register file
// - mmr_bank   out  1                      bank of the issued write; always 0 when BANKS=1
// - mmr_reg    out  8                      register index of the issued write
// - mmr_din    out  8                      data of the issued write
// BEHAVIOUR
// - Reset: FIFO empty, ovf=0, reg latch=0, bank latch=0, FSM=IDLE, wait counter=0.
//   - All outputs are 0 during reset, except dout, which shows the live status inputs.
//   - Reset asserted mid-transfer discards every queued entry and cancels any wait.
// - Access detection: wr_act = !cs_n & !wr_n. One access is taken on the 0->1 clk-edge transition of wr_act.
//   - Holding the strobe low does not repeat the access.
// - Address access (addr[0]=0): reg latch <= din. Bank latch <= addr[1] when BANKS=2, else 0. FIFO untouched.
// - Data access (addr[0]=1): push {bank latch, reg latch, din}.
//   - If the FIFO is full: the entry is dropped, ovf <= 1, and FIFO contents are unchanged.
//   - A pop and a push in the same clk are both honoured; count is unchanged.
// - FSM (counter is advanced only on cenop):
//   - IDLE: when the FIFO is non-empty and cenop=1, pop the head. Drive mmr_bank/reg/din with it and pulse mmr_write for exactly that clk. Load the counter with DATA_WAIT-1, then go to WAIT.
//   - WAIT: decrement the counter on each cenop. At 0 with cenop=1, go to IDLE.
//   - Spacing between two mmr_write pulses is therefore exactly DATA_WAIT cenop cycles.
//   - Latency from the data access to mmr_write is the first cenop at least 1 clk after the push, when IDLE.
// - mmr_bank, mmr_reg and mmr_din hold their last issued values between pulses.
// - busy = (FIFO count != 0) | (state == WAIT).
// - FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
//   - full = MSBs differ and LSBs are equal; empty = pointers equal.
// - ovf is sticky. It clears on a status read (cs_n=0, wr_n=1, addr[0]=0) and on reset.
// - dout[7:5] = {~irq_n, flag_A, flag_B}; dout[4:0] depend on the macro below.
// CONFIGURATION
// - JTOPL_CPU_STATUS_EN defined: dout[4:0] = {ovf, 3'b000, busy}. The host can poll busy and ovf.
// - JTOPL_CPU_STATUS_EN undefined: dout[4:0] = 5'd6 (legacy chip ID).
//   - ovf logic still runs internally but is not visible on dout.
// TESTING
// - Write addr 0x20, then data 0x41 -> one mmr_write with reg=0x20, din=0x41, bank=0.
//   - busy high for 84 cenop cycles after issue.
// - Three back-to-back data writes to 0xA0/0xB0/0xC0 -> three pulses in order, spaced exactly 84 cenop apart.
//   - FIFO then empty; busy=0.
// - FIFO_DEPTH=4, six data writes during WAIT -> entries 5 and 6 are dropped and ovf=1.
//   - With the macro: dout[4]=1 until a status read, then 0.
// - BANKS=2: address access with addr=2'b10, din=0x05, then data 0x30 -> mmr_bank=1, mmr_reg=0x05, mmr_din=0x30.
// - Assert rst_n=0 with 3 entries queued in WAIT -> no further mmr_write, busy=0.
//   - After release: first new write issues normally.
// - Macro undefined, irq_n=0, flag_A=1, flag_B=0 -> dout=8'hC6. cenop held low -> no mmr_write while the FIFO is non-empty.

Source files
------------

// File: rtl/jtopl_cpu_fifo.sv
// jtopl_cpu_fifo -- CPU-side write front end for the OPL core.
//
// Host writes are split into address accesses, which latch the register
// index and bank, and data accesses, which queue {bank, reg, data} entries
// in a small FIFO. Queued entries are replayed to jtopl_mmr one at a time,
// paced on cenop. Consecutive mmr writes are spaced DATA_WAIT cenop cycles
// apart to honour the chip's write-recovery time.
//
// Optional feature macro: JTOPL_CPU_STATUS_EN
//   defined   : dout[4:0] = {ovf, 3'b000, busy}
//   undefined : dout[4:0] = 5'd6 (legacy chip ID). ovf is still tracked internally.
//
// Parameters
//   FIFO_DEPTH : queue entries, power of two, 2..16
//   BANKS      : 1 = single bank (addr is 1 bit), 2 = bank select on addr[1]
//   DATA_WAIT  : cenop cycles between two consecutive mmr writes
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   cenop                 : operator clock enable, paces issue and recovery wait
//   din, addr, cs_n, wr_n : host bus (addr[0]: 0 = address port, 1 = data port)
//   flag_A, flag_B, irq_n : timer status inputs, shown in dout[7:5]
//   dout                  : status byte
//   busy                  : FIFO non-empty or recovery wait in progress
//   mmr_write             : single-clk write pulse to the register file
//   mmr_bank/reg/din      : fields of the issued write, held between pulses
module jtopl_cpu_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int BANKS      = 1,
    parameter int DATA_WAIT  = 84
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cenop,
    input  logic [7:0]       din,
    input  logic [BANKS-1:0] addr,
    input  logic             cs_n,
    input  logic             wr_n,
    input  logic             flag_A,
    input  logic             flag_B,
    input  logic             irq_n,
    output logic [7:0]       dout,
    output logic             busy,
    output logic             mmr_write,
    output logic             mmr_bank,
    output logic [7:0]       mmr_reg,
    output logic [7:0]       mmr_din
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (DATA_WAIT > 1) ? $clog2(DATA_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(DATA_WAIT - 1);

    typedef struct packed {
        logic       bank;
        logic [7:0] rg;
        logic [7:0] data;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // ---------------------------------------------------------------
    // Host access detection
    // ---------------------------------------------------------------
    logic wr_act, wr_act_q, take, take_addr, take_data;
    logic addr_bank, status_rd;

    assign wr_act    = !cs_n && !wr_n;
    assign take      = wr_act && !wr_act_q;        // one access per strobe
    assign take_addr = take && !addr[0];
    assign take_data = take &&  addr[0];
    assign addr_bank = (BANKS == 2) ? addr[BANKS-1] : 1'b0;
    assign status_rd = !cs_n && wr_n && !addr[0];

    logic       bank_latch;
    logic [7:0] reg_latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_act_q   <= 1'b0;
            reg_latch  <= 8'd0;
            bank_latch <= 1'b0;
        end else begin
            wr_act_q <= wr_act;
            if (take_addr) begin
                reg_latch  <= din;
                bank_latch <= addr_bank;
            end
        end
    end

    // ---------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit to tell full from empty
    // ---------------------------------------------------------------
    entry_t         mem [FIFO_DEPTH];
    logic [PW-1:0]  wp, rp;
    logic           empty, full, push, drop, pop;
    entry_t         head;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    // Full is judged on the pre-edge occupancy, so a push arriving on the
    // same clk as a pop from a full queue is still dropped.
    assign push  = take_data && !full;
    assign drop  = take_data &&  full;
    assign head  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wp[AW-1:0]] <= '{bank: bank_latch, rg: reg_latch, data: din};
    end

    logic ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            ovf <= 1'b0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            if (drop)
                ovf <= 1'b1;
            else if (status_rd)
                ovf <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Issue FSM
    // ---------------------------------------------------------------
    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter leaves WAIT on the same cenop that brings it to zero, so
    // the next IDLE cenop issues exactly DATA_WAIT cenops after the last one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && cenop) begin
                    pop     = 1'b1;
                    cnt_nxt = WAIT_LOAD;
                    if (DATA_WAIT > 1) state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cenop) begin
                    if (cnt <= CW'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmr_write <= 1'b0;
            mmr_bank  <= 1'b0;
            mmr_reg   <= 8'd0;
            mmr_din   <= 8'd0;
        end else begin
            mmr_write <= pop;
            if (pop) begin
                mmr_bank <= head.bank;
                mmr_reg  <= head.rg;
                mmr_din  <= head.data;
            end
        end
    end

    // ---------------------------------------------------------------
    // Status
    // ---------------------------------------------------------------
    assign busy = !empty || (state == WAIT);

`ifdef JTOPL_CPU_STATUS_EN
    assign dout = {~irq_n, flag_A, flag_B, ovf, 3'b000, busy};
`else
    assign dout = {~irq_n, flag_A, flag_B, 5'd6};
`endif

endmodule

// File: tb/tb_jtopl_cpu_fifo.sv
module tb_jtopl_cpu_fifo;

    localparam int FD = 4;
    localparam int DW = 84;

    logic       clk = 1'b0;
    logic       rst_n, cenop, cs_n, wr_n, flag_A, flag_B, irq_n;
    logic [7:0] din;
    logic [1:0] a;
    logic       cen_hold = 1'b0;

    logic [7:0] dout0, mr0, md0, dout1, mr1, md1;
    logic       busy0, mw0, mb0, busy1, mw1, mb1;

    always #5 clk = ~clk;

    jtopl_cpu_fifo #(.FIFO_DEPTH(FD), .BANKS(1), .DATA_WAIT(DW)) u0 (
        .clk(clk), .rst_n(rst_n), .cenop(cenop), .din(din), .addr(a[0]),
        .cs_n(cs_n), .wr_n(wr_n), .flag_A(flag_A), .flag_B(flag_B), .irq_n(irq_n),
        .dout(dout0), .busy(busy0), .mmr_write(mw0), .mmr_bank(mb0),
        .mmr_reg(mr0), .mmr_din(md0));

    jtopl_cpu_fifo #(.FIFO_DEPTH(FD), .BANKS(2), .DATA_WAIT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .cenop(cenop), .din(din), .addr(a),
        .cs_n(cs_n), .wr_n(wr_n), .flag_A(flag_A), .flag_B(flag_B), .irq_n(irq_n),
        .dout(dout1), .busy(busy1), .mmr_write(mw1), .mmr_bank(mb1),
        .mmr_reg(mr1), .mmr_din(md1));

    // ---------------- reference model ----------------
    typedef struct {
        logic       bank;
        logic [7:0] rg;
        logic [7:0] d;
        int         c;      // cenop count at the push edge
    } ent_t;

    ent_t       exq[$];
    logic [7:0] m_reg = 8'd0;
    logic       m_ovf = 1'b0;
    int         cen_cnt = 0;
    int         prev_issue = 0;
    bit         have_prev = 0;
    int         nw0 = 0;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) cenop = cen_hold ? 1'b0 : 1'($urandom & 1);
    always @(posedge clk) if (cenop) cen_cnt++;

    // An entry issues on the first cenop after its push, but never sooner
    // than DW cenops after the previous issue.
    always @(negedge clk) begin
        if (rst_n && mw0) begin
            nw0++;
            if (exq.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                ent_t e;
                int   want;
                e    = exq.pop_front();
                want = e.c + 1;
                if (have_prev && prev_issue + DW > want) want = prev_issue + DW;
                chk("mmr_reg", mr0, e.rg);
                chk("mmr_din", md0, e.d);
                chk("mmr_bank", mb0, e.bank);
                chk("issue_cenop", cen_cnt, want);
                prev_issue = cen_cnt;
                have_prev  = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic acc(input logic [1:0] ad, input logic [7:0] d, input int hold = 1);
        @(negedge clk);
        a = ad; din = d; cs_n = 1'b0; wr_n = 1'b0;
        @(posedge clk);
        #1;
        if (!ad[0]) m_reg = d;
        else if (exq.size() >= FD) m_ovf = 1'b1;
        else exq.push_back('{bank: 1'b0, rg: m_reg, d: d, c: cen_cnt});
        for (int i = 1; i < hold; i++) @(posedge clk);
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic status_read();
        @(negedge clk);
        a = 2'b00; cs_n = 1'b0; wr_n = 1'b1;
        @(posedge clk);
        #1 m_ovf = 1'b0;
        @(negedge clk);
        cs_n = 1'b1;
    endtask

    task automatic check_dout(input string tag, input logic eb);
        logic [7:0] e;
`ifdef JTOPL_CPU_STATUS_EN
        e = {~irq_n, flag_A, flag_B, m_ovf, 3'b000, eb};
`else
        e = {~irq_n, flag_A, flag_B, 5'd6};
`endif
        chk(tag, dout0, e);
    endtask

    task automatic wait_issue(input string tag);
        int k = 0;
        @(negedge clk);
        while (!mw0 && k < 1000) begin @(negedge clk); k++; end
        chk(tag, mw0, 1);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exq.size() != 0 || busy0) && k < 4000) begin @(negedge clk); k++; end
        chk({tag, "_queue"}, exq.size(), 0);
        chk({tag, "_busy"}, busy0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exq.delete();
        m_reg = 8'd0; m_ovf = 1'b0; have_prev = 0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; a = 2'b00; din = 8'h00;
        flag_A = 1'($urandom & 1); flag_B = 1'($urandom & 1); irq_n = 1'($urandom & 1);
        repeat (3) @(negedge clk);
        chk("rst_write", mw0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_reg", mr0, 0);
        chk("rst_din", md0, 0);
        chk("rst_bank", mb0, 0);
        check_dout("rst_dout", 1'b0);
        rst_n = 1'b1;

        // single write
        acc(2'b00, 8'h20);
        acc(2'b01, 8'h41);
        wait_issue("first_issue");
        chk("busy_after_issue", busy0, 1);
        drain("single");

        // three back-to-back, random data
        acc(2'b00, 8'hA0); acc(2'b01, 8'($urandom));
        acc(2'b00, 8'hB0); acc(2'b01, 8'($urandom));
        acc(2'b00, 8'hC0); acc(2'b01, 8'($urandom));
        drain("b2b");
        check_dout("idle_dout", 1'b0);

        // overflow: six writes while in WAIT
        acc(2'b00, 8'($urandom)); acc(2'b01, 8'($urandom));
        wait_issue("ovf_first");
        for (int i = 0; i < 6; i++) acc(2'b01, 8'($urandom));
        chk("ovf_model", m_ovf, 1);
        chk("ovf_queue", exq.size(), FD);
        check_dout("ovf_set", 1'b1);
        status_read();
        check_dout("ovf_clr", 1'b1);
        drain("ovf");

        // strobe held low: a single access
        n = nw0;
        acc(2'b01, 8'($urandom), 4);
        drain("hold");
        chk("hold_count", nw0 - n, 1);

        // random traffic
        for (int i = 0; i < 10; i++) acc(2'($urandom), 8'($urandom));
        drain("rand");

        // reset mid-transfer with 3 queued
        acc(2'b01, 8'($urandom));
        wait_issue("rst_first");
        for (int i = 0; i < 3; i++) acc(2'b01, 8'($urandom));
        n = nw0;
        do_reset();
        chk("midrst_busy", busy0, 0);
        chk("midrst_write", mw0, 0);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("midrst_none", nw0 - n, 0);
        chk("midrst_busy_after", busy0, 0);
        acc(2'b01, 8'($urandom));           // reg latch back at 0
        drain("after_rst");

        // bank select on the 2-bank instance
        do_reset();
        rst_n = 1'b1;
        acc(2'b10, 8'h05);
        acc(2'b01, 8'h30);
        n = 0;
        while (!mw1 && n < 1000) begin @(negedge clk); n++; end
        chk("bank_issue", mw1, 1);
        chk("bank_bank", mb1, 1);
        chk("bank_reg", mr1, 8'h05);
        chk("bank_din", md1, 8'h30);
        drain("bank");

        // cenop held low, fixed status inputs
        irq_n = 1'b0; flag_A = 1'b1; flag_B = 1'b0;
        cen_hold = 1'b1;
        n = nw0;
        acc(2'b01, 8'($urandom));
        repeat (50) @(negedge clk);
        chk("nocen_none", nw0 - n, 0);
        chk("nocen_busy", busy0, 1);
        check_dout("nocen_dout", 1'b1);
`ifndef JTOPL_CPU_STATUS_EN
        chk("legacy_C6", dout0, 8'hC6);
`endif
        cen_hold = 1'b0;
        drain("nocen");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
